// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter family.
// The FSM state enum lives here so that checkers and later arbiters can reuse it.
package dmem_arbiter_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_arbiter_checker.sv
// Protocol checker for dmem_arbiter: one-hot pulses, write strobe only with a grant,
// and a bound on how long any core may wait with req held.
module dmem_arbiter_checker #(
    parameter int NUM_CORES = 4
) (
    input logic                 clk,
    input logic                 rst,
    input logic [NUM_CORES-1:0] req,
    input logic [NUM_CORES-1:0] gnt,
    input logic [NUM_CORES-1:0] rvalid,
    input logic                 mem_we
);

    logic [7:0] wait_r [NUM_CORES];

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rvalid));
    // gnt pulses exactly in ISSUE, so a write strobe without a grant is outside ISSUE
    a_we_in_issue: assert property (@(posedge clk) disable iff (rst) mem_we |-> (gnt != '0));

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_wait
        // Saturating count of cycles core k has waited with req high and no grant.
        always_ff @(posedge clk) begin
            if (rst || !req[k] || gnt[k]) begin
                wait_r[k] <= 8'd0;
            end else if (wait_r[k] != 8'hFF) begin
                wait_r[k] <= wait_r[k] + 8'd1;
            end
        end

        a_no_starve: assert property (@(posedge clk) disable iff (rst)
            wait_r[k] <= 8'(4 * NUM_CORES));
    end

endmodule

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, wrapping.
// Kept free of state so other arbiters can drop it in unchanged.
module rr_pick #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     sel,
    output logic                 any_req
);

    int idx_s;

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        idx_s   = 0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            idx_s = (int'(ptr) + i) % NUM_CORES;
            if (req[idx_s]) begin
                sel     = IDX_W'(idx_s);
                any_req = 1'b1;
            end else begin
                sel     = sel;
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores shared access to one data memory.
// Every output is registered; grant/strobe values are loaded on the edge that enters ISSUE.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_next_s;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     sel_r;
    logic [IDX_W-1:0]     pick_s;
    logic                 any_req_s;
    logic [NUM_CORES-1:0] gnt_r;
    logic [NUM_CORES-1:0] rvalid_r;
    logic [DATA_W-1:0]    rdata_r;
    logic                 mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_wdata_r;
    logic                 busy_r;

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_r),
        .sel     (pick_s),
        .any_req (any_req_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; read/write direction comes from the strobe latched at selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_we_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_WAIT: state_next_s = ST_RESP;
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Selection commit, pointer advance, memory-side mux and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            sel_r       <= '0;
            gnt_r       <= '0;
            rvalid_r    <= '0;
            rdata_r     <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            gnt_r    <= '0;
            rvalid_r <= '0;
            mem_we_r <= 1'b0;
            busy_r   <= (state_next_s != ST_IDLE);
            if (state_r == ST_IDLE && any_req_s) begin
                sel_r       <= pick_s;
                ptr_r       <= (pick_s == IDX_W'(NUM_CORES - 1)) ? '0 : pick_s + IDX_W'(1);
                gnt_r       <= ONE_HOT0 << pick_s;
                mem_we_r    <= we[pick_s];
                mem_addr_r  <= addr[int'(pick_s) * ADDR_W +: ADDR_W];
                mem_wdata_r <= wdata[int'(pick_s) * DATA_W +: DATA_W];
            end
            if (state_r == ST_WAIT) begin
                rdata_r  <= mem_rdata;
                rvalid_r <= ONE_HOT0 << sel_r;
            end
        end
    end

    assign gnt       = gnt_r;
    assign rvalid    = rvalid_r;
    assign rdata     = rdata_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NUM_CORES SHALL default to 4 and set the number of requesting cores, with a legal range of 2..8.
REQ-002 Parameter ADDR_W SHALL default to 16 and set the data-memory address width.
REQ-003 Parameter DATA_W SHALL default to 16 and set the data-memory word width.
REQ-004 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, and be a synchronous, active-high reset.
REQ-006 Port req SHALL be an input, NUM_CORES bits wide, carrying one access-request bit per core.
REQ-007 Port we SHALL be an input, NUM_CORES bits wide, with per-core 1=write and 0=read.
REQ-008 Port addr SHALL be an input, NUM_CORES*ADDR_W bits wide, with core k's address in slice k.
REQ-009 Port wdata SHALL be an input, NUM_CORES*DATA_W bits wide, with core k's write data in slice k.
REQ-010 Port gnt SHALL be an output, NUM_CORES bits wide, and be a one-hot, one-cycle grant pulse.
REQ-011 Port rvalid SHALL be an output, NUM_CORES bits wide, and be a one-hot, one-cycle read-data-valid pulse.
REQ-012 Port rdata SHALL be an output, DATA_W bits wide, and carry the read data shared by all cores.
REQ-013 Port mem_we SHALL be an output, 1 bit wide, and drive the data-memory write enable.
REQ-014 Port mem_addr SHALL be an output, ADDR_W bits wide, and drive the data-memory address.
REQ-015 Port mem_wdata SHALL be an output, DATA_W bits wide, and drive the data-memory write data.
REQ-016 Port mem_rdata SHALL be an input, DATA_W bits wide, and be valid one cycle after its address was presented.
REQ-017 Port busy SHALL be an output, 1 bit wide, and be high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE with req nonzero, the arbiter SHALL register the winner index sel and go to ISSUE next cycle; with req zero it SHALL stay in IDLE.
REQ-020 Winner selection SHALL be round-robin: the first set req bit searching upward from ptr, wrapping from NUM_CORES-1 to 0.
REQ-021 On entering ISSUE, ptr SHALL become (sel+1) mod NUM_CORES.
REQ-022 In ISSUE, mem_addr and mem_wdata SHALL equal core sel's slices, mem_we SHALL equal we[sel], and gnt[sel] SHALL be 1 for exactly this cycle.
REQ-023 From ISSUE, a write SHALL go to IDLE and a read SHALL go to WAIT.
REQ-024 In WAIT, rdata SHALL be loaded from mem_rdata at the end of the cycle, and the FSM SHALL then go to RESP.
REQ-025 In RESP, rvalid[sel] SHALL be 1 for one cycle, and the FSM SHALL then go to IDLE.
REQ-026 rdata SHALL hold its value until the next read capture.
REQ-027 Outside ISSUE, mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last ISSUE values.
REQ-028 Latency: a write SHALL be granted 2 cycles after req is sampled in IDLE; read data SHALL arrive 4 cycles after.
REQ-029 Throughput SHALL be one write per 2 cycles and one read per 4 cycles.
REQ-030 A core SHALL hold req, we, addr and wdata stable until its gnt pulse.
REQ-031 A core MAY drop req the cycle after gnt, or keep req high to request a further access.
REQ-032 Inputs of a core that drops req before the IDLE sample SHALL be ignored, and it SHALL receive no gnt.
REQ-033 If the selected core drops req during ISSUE, the access SHALL still complete, because selection is committed in IDLE.
REQ-034 A core that holds req SHALL be granted within NUM_CORES arbitration rounds, so there is no starvation.
REQ-035 gnt and rvalid SHALL never have more than one bit set.

Reset
REQ-036 While rst is high: state SHALL be IDLE, ptr and sel SHALL be 0, and gnt, rvalid, mem_we and busy SHALL be 0.
REQ-037 While rst is high, rdata, mem_addr and mem_wdata SHALL be 0.
REQ-038 Reset asserted in ISSUE, WAIT or RESP SHALL abort the access with no gnt, rvalid or mem_we in the following cycle.
REQ-039 The first arbitration after reset SHALL start from core 0.

Structure
REQ-040 The shared package SHALL hold the FSM state enum (IDLE, ISSUE, WAIT, RESP) and the default widths ADDR_W=16, DATA_W=16, NUM_CORES=4.
REQ-041 The round-robin priority search SHALL be one sub-module, rr_pick, taking inputs req and ptr and producing outputs sel and any_req; it SHALL be combinational and reused by later arbiters.
REQ-042 The top level SHALL contain the FSM, the ptr and sel registers, the rdata register and the memory-side multiplexing.

Verification
REQ-043 Single write: reset, then req=0001, we[0]=1, addr0=0x0010, wdata0=0xBEEF -> gnt=0001 two cycles later with mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF; a later read of 0x0010 returns 0xBEEF.
REQ-044 Read latency: memory preloaded with 0x1234 at 0x0020, core 2 reads 0x0020 -> gnt=0100 at t+2, rvalid=0100 at t+4, rdata=0x1234.
REQ-045 Round-robin: req=1111 held, all writes -> gnt sequence 0001, 0010, 0100, 1000, 0001, with no repeat before all four are served.
REQ-046 Wrap and skip: ptr=3 after a grant to core 2, req=0101 -> next gnt=0001, then 0100.
REQ-047 Withdrawal and reset: core 1 raises req, drops it before the IDLE sample -> no gnt to core 1; rst pulsed during WAIT of a read -> no rvalid, busy=0, next grant starts from core 0.
REQ-048 A protocol checker SHALL flag non-one-hot gnt/rvalid, mem_we outside ISSUE, and any requester waiting more than 4*NUM_CORES cycles.
